icache: RTL and testbench

Direct-mapped, read-only instruction cache between the fetch unit and the memory read port. It accepts one word-fetch request at a time from the fetch unit and answers hits from local storage. On a miss it refills a whole block with a fixed-length burst read, then returns the requested word. A fence.i indication from the fetch unit invalidates every line.

---
 rtl/icache.sv | 156 +++++++++++++++
 tb/tb_icache.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between the fetch unit and a
// burst read port. Misses refill a whole line, fence.i invalidates all lines.
// Build option: define ICACHE_BYPASS_EN to turn every fetch into a
// single-beat uncached read (array unused, fence ignored).
module icache #(
    parameter int unsigned LINE_NUM       = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_valid_i,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_ready_o,
    output logic [31:0] ifu_data_o,
    input  logic        ifu_fence_i,
    output logic        Icache_r_valid_o,
    output logic [31:0] Icache_r_addr_o,
    input  logic        Icache_r_ready_i,
    input  logic [31:0] Icache_r_data_i,
    output logic [7:0]  Icache_r_len_o,
    input  logic        Icache_r_last_i
);

    localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W = $clog2(LINE_NUM);
    localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [29:0] waddr_q;
    logic [31:0] rdata_q;
    logic [31:0] miss_addr_c;
    logic        hit_c;
    logic [31:0] hit_data_c;
    logic        beat_c;
    logic        done_c;

    assign beat_c = (state_q == S_FILL) && Icache_r_ready_i;
    assign done_c = beat_c && Icache_r_last_i;

`ifdef ICACHE_BYPASS_EN
    logic unused_c;
    assign unused_c       = ^{ifu_fence_i, ifu_addr_i[1:0]};
    assign hit_c          = 1'b0;
    assign hit_data_c     = '0;
    assign miss_addr_c    = {waddr_q, 2'b00};
    assign Icache_r_len_o = 8'd0;

    // Capture the single beat as the response word
    always_ff @(posedge clock) begin
        if (done_c) rdata_q <= Icache_r_data_i;
    end
`else
    logic [WORDS_PER_LINE-1:0][31:0] data_q [LINE_NUM];
    logic [TAG_W-1:0]                tag_q  [LINE_NUM];
    logic [LINE_NUM-1:0]             valid_q;
    logic [WORDS_PER_LINE-1:0][31:0] line_q;
    logic [WORDS_PER_LINE-1:0][31:0] fill_line_c;
    logic [OFF_W-1:0]                cnt_q;
    logic [OFF_W-1:0]                off_c;
    logic [IDX_W-1:0]                idx_c;
    logic [TAG_W-1:0]                tag_c;
    logic                            unused_c;

    assign unused_c       = ^ifu_addr_i[1:0];
    assign off_c          = waddr_q[OFF_W-1:0];
    assign idx_c          = waddr_q[OFF_W +: IDX_W];
    assign tag_c          = waddr_q[29 -: TAG_W];
    assign hit_c          = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
    assign hit_data_c     = data_q[idx_c][off_c];
    assign miss_addr_c    = {tag_c, idx_c, (OFF_W + 2)'(0)};
    assign Icache_r_len_o = 8'(WORDS_PER_LINE - 1);

    // Line buffer with the current beat merged in at the beat counter
    always_comb begin
        fill_line_c        = line_q;
        fill_line_c[cnt_q] = Icache_r_data_i;
    end

    // Valid bits and beat counter: fence clears in IDLE, last beat sets
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (state_q == S_IDLE && ifu_fence_i) valid_q <= '0;
            if (done_c) begin
                valid_q[idx_c] <= 1'b1;
                cnt_q          <= '0;
            end else if (beat_c) begin
                cnt_q <= cnt_q + OFF_W'(1);
            end
        end
    end

    // Line assembly, array write and response word capture (no reset needed)
    always_ff @(posedge clock) begin
        if (beat_c) line_q <= fill_line_c;
        if (done_c) begin
            data_q[idx_c] <= fill_line_c;
            tag_q[idx_c]  <= tag_c;
            rdata_q       <= fill_line_c[off_c];
        end
    end
`endif

    // Request address latch, taken when a fetch is accepted in IDLE
    always_ff @(posedge clock) begin
        if (state_q == S_IDLE && ifu_valid_i) waddr_q <= ifu_addr_i[31:2];
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (ifu_valid_i) state_d = S_LOOKUP;
            S_LOOKUP: state_d = hit_c ? S_IDLE : S_FILL;
            S_FILL:   if (done_c) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode: hit and refill responses, burst request during FILL
    always_comb begin
        ifu_ready_o      = 1'b0;
        ifu_data_o       = '0;
        Icache_r_valid_o = 1'b0;
        Icache_r_addr_o  = '0;
        case (state_q)
            S_LOOKUP: begin
                if (hit_c) begin
                    ifu_ready_o = 1'b1;
                    ifu_data_o  = hit_data_c;
                end
            end
            S_FILL: begin
                Icache_r_valid_o = 1'b1;
                Icache_r_addr_o  = miss_addr_c;
            end
            S_RESP: begin
                ifu_ready_o = 1'b1;
                ifu_data_o  = rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache (default caching build).
module tb_icache;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_valid_i;
    logic [31:0] ifu_addr_i;
    logic        ifu_ready_o;
    logic [31:0] ifu_data_o;
    logic        ifu_fence_i;
    logic        Icache_r_valid_o;
    logic [31:0] Icache_r_addr_o;
    logic        Icache_r_ready_i;
    logic [31:0] Icache_r_data_i;
    logic [7:0]  Icache_r_len_o;
    logic        Icache_r_last_i;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        int          fence;   // 0 none, 1 one cycle before, 2 same cycle
        int          stall;   // idle cycles before each beat
        logic        miss;
        logic [31:0] data;
        logic [31:0] raddr;
        string       name;
    } vec_t;

    vec_t vecs[12];

    always #5 clock = ~clock;

    icache dut (
        .clock            (clock),
        .reset            (reset),
        .ifu_valid_i      (ifu_valid_i),
        .ifu_addr_i       (ifu_addr_i),
        .ifu_ready_o      (ifu_ready_o),
        .ifu_data_o       (ifu_data_o),
        .ifu_fence_i      (ifu_fence_i),
        .Icache_r_valid_o (Icache_r_valid_o),
        .Icache_r_addr_o  (Icache_r_addr_o),
        .Icache_r_ready_i (Icache_r_ready_i),
        .Icache_r_data_i  (Icache_r_data_i),
        .Icache_r_len_o   (Icache_r_len_o),
        .Icache_r_last_i  (Icache_r_last_i)
    );

    // Memory contents: block 0x3000_0000 holds 0x11..0x44, elsewhere addr^pattern
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w[31:4] == 28'h3000000) return 32'h11 * (32'(w[3:2]) + 32'd1);
        return w ^ 32'h5A5A5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One fetch: drive request, serve any burst, compare the response
    task automatic fetch(input vec_t v);
        logic        saw;
        logic        done;
        int          beat;
        int          gap;
        logic [31:0] e;
        if (v.fence == 1) begin
            ifu_fence_i = 1'b1;
            @(negedge clock);
            ifu_fence_i = 1'b0;
        end
        ifu_addr_i  = v.addr;
        ifu_valid_i = 1'b1;
        ifu_fence_i = (v.fence == 2);
        exp_q.push_back(v.data);
        saw  = 1'b0;
        done = 1'b0;
        beat = 0;
        gap  = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clock);
            ifu_fence_i      = 1'b0;
            Icache_r_ready_i = 1'b0;
            Icache_r_last_i  = 1'b0;
            Icache_r_data_i  = '0;
            if (ifu_ready_o) begin
                done        = 1'b1;
                ifu_valid_i = 1'b0;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL %s_spurious: ifu_ready_o with no request pending", v.name);
                end else begin
                    e = exp_q.pop_front();
                    check({v.name, "_data"}, ifu_data_o, e);
                end
            end else if (Icache_r_valid_o) begin
                if (!saw) begin
                    saw = 1'b1;
                    check({v.name, "_raddr"}, Icache_r_addr_o, v.raddr);
                    check({v.name, "_len"}, 32'(Icache_r_len_o), 32'd3);
                end
                if (gap < v.stall) begin
                    gap++;
                end else begin
                    gap              = 0;
                    Icache_r_ready_i = 1'b1;
                    Icache_r_data_i  = mem_word(v.raddr + 32'(beat * 4));
                    Icache_r_last_i  = (beat == 3);
                    beat++;
                end
            end
        end
        if (!done) begin
            tests++;
            fails++;
            ifu_valid_i = 1'b0;
            $display("FAIL %s_timeout: ifu_ready_o got 0 expected 1 within 400 cycles", v.name);
        end
        check({v.name, "_miss"}, 32'(saw), 32'(v.miss));
        @(negedge clock);
        check({v.name, "_single_ready"}, 32'(ifu_ready_o), 32'd0);
        check({v.name, "_data_idle"}, ifu_data_o, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   beats;
        vec_t v;

        vecs[0]  = '{32'h3000_0008, 0, 0, 1'b1, 32'h0000_0033, 32'h3000_0000, "cold_miss"};
        vecs[1]  = '{32'h3000_000C, 0, 0, 1'b0, 32'h0000_0044, 32'h3000_0000, "hit_after_fill"};
        vecs[2]  = '{32'h3000_0100, 0, 0, 1'b1, 32'h6A5A_5B5A, 32'h3000_0100, "conflict_a"};
        vecs[3]  = '{32'h3000_0000, 0, 0, 1'b1, 32'h0000_0011, 32'h3000_0000, "conflict_b"};
        vecs[4]  = '{32'h3000_0004, 0, 0, 1'b0, 32'h0000_0022, 32'h3000_0000, "hit_word1"};
        vecs[5]  = '{32'h3000_0004, 1, 0, 1'b1, 32'h0000_0022, 32'h3000_0000, "fence_miss"};
        vecs[6]  = '{32'h3000_0010, 0, 3, 1'b1, 32'h6A5A_5A4A, 32'h3000_0010, "stall3"};
        vecs[7]  = '{32'h3000_001C, 0, 0, 1'b0, 32'h6A5A_5A46, 32'h3000_0010, "stall3_hit"};
        vecs[8]  = '{32'h1234_5678, 0, 1, 1'b1, 32'h486E_0C22, 32'h1234_5670, "far_miss"};
        vecs[9]  = '{32'h1234_5670, 0, 0, 1'b0, 32'h486E_0C2A, 32'h1234_5670, "far_hit"};
        vecs[10] = '{32'h3000_0004, 2, 0, 1'b1, 32'h0000_0022, 32'h3000_0000, "fence_same_cycle"};
        vecs[11] = '{32'h3000_000B, 0, 0, 1'b0, 32'h0000_0033, 32'h3000_0000, "low_bits_ignored"};

        reset            = 1'b1;
        ifu_valid_i      = 1'b0;
        ifu_addr_i       = '0;
        ifu_fence_i      = 1'b0;
        Icache_r_ready_i = 1'b0;
        Icache_r_data_i  = '0;
        Icache_r_last_i  = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_ready", 32'(ifu_ready_o), 32'd0);
        check("reset_data", ifu_data_o, 32'd0);
        check("reset_rvalid", 32'(Icache_r_valid_o), 32'd0);
        check("reset_raddr", Icache_r_addr_o, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) fetch(vecs[i]);

        // Reset after two beats of a refill: burst dropped, no response
        ifu_addr_i  = 32'h3000_0020;
        ifu_valid_i = 1'b1;
        beats       = 0;
        for (int c = 0; c < 50 && beats < 2; c++) begin
            @(negedge clock);
            Icache_r_ready_i = 1'b0;
            if (ifu_ready_o) check("rst_burst_no_ready", 32'(ifu_ready_o), 32'd0);
            if (Icache_r_valid_o) begin
                Icache_r_ready_i = 1'b1;
                Icache_r_data_i  = mem_word(32'h3000_0020 + 32'(beats * 4));
                Icache_r_last_i  = 1'b0;
                beats++;
            end
        end
        check("rst_burst_beats", 32'(beats), 32'd2);
        @(negedge clock);
        Icache_r_ready_i = 1'b0;
        ifu_valid_i      = 1'b0;
        reset            = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_burst_rvalid", 32'(Icache_r_valid_o), 32'd0);
        for (int c = 0; c < 3; c++) begin
            check("rst_burst_ready", 32'(ifu_ready_o), 32'd0);
            @(negedge clock);
        end

        v = '{32'h3000_0020, 0, 0, 1'b1, 32'h6A5A_5A7A, 32'h3000_0020, "rst_refill"};
        fetch(v);
        v = '{32'h3000_0008, 0, 0, 1'b1, 32'h0000_0033, 32'h3000_0000, "rst_cold"};
        fetch(v);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
